// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg
//   Shared types and constants for the MR-stage read responder.
//   state_t      : responder FSM states
//   WORD_BYTES   : bytes per RAM word
//   DEF_TIMEOUT  : default RAM wait limit when MEM_RD_TIMEOUT_EN is defined
//   ERR_VALUE    : data returned on a timed-out read
package mem_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RESP,
    DRAIN
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam logic [31:0] ERR_VALUE = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_rd_align.sv
// mem_rd_align
//   Combinational byte-lane merge of two consecutive little-endian words.
//   Returns the 32-bit word starting at byte offset off within {hi,lo}.
//   Ports:
//     lo   in  32  word at the lower address
//     hi   in  32  word at the next address
//     off  in  2   byte offset into lo
//     data out 32  merged word
module mem_rd_align
  import mem_rd_pkg::*;
(
  input  logic [8*WORD_BYTES-1:0] lo,
  input  logic [8*WORD_BYTES-1:0] hi,
  input  logic [1:0]              off,
  output logic [8*WORD_BYTES-1:0] data
);

  localparam int WB = 8 * WORD_BYTES;

  logic [2*WB-1:0] shifted;
  logic            unused_hi_bytes;

  // Shift the 64-bit pair right by whole bytes; the low word is the result.
  assign shifted         = {hi, lo} >> {off, 3'b000};
  assign data            = shifted[WB-1:0];
  assign unused_hi_bytes = ^shifted[2*WB-1:WB];

endmodule

// File: rtl/mem_rd_responder.sv
// mem_rd_responder
//   Memory-side responder for the MR-stage read handshake. Accepts a byte
//   address, performs one RAM word read (aligned) or two (unaligned, next
//   word wraps modulo 2^AW), merges bytes and returns them with a one-cycle
//   read_finished pulse. A request withdrawn mid-access is drained from the
//   RAM without a response.
//   Optional feature macro: MEM_RD_TIMEOUT_EN (RAM wait timeout, rd_err).
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     mre, addr        request and byte address from the MR stage
//     read_finished    one-cycle completion pulse
//     mem_val          merged read data, held until the next completion
//     busy             high whenever not IDLE
//     ram_re, ram_addr RAM read request and word address
//     ram_rdata        RAM read data
//     ram_rvalid       RAM completion
//     rd_err           timeout flag, with read_finished
module mem_rd_responder
  import mem_rd_pkg::*;
#(
  parameter int AW      = 30,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mre,
  input  logic [31:0]   addr,
  output logic          read_finished,
  output logic [31:0]   mem_val,
  output logic          busy,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  input  logic [31:0]   ram_rdata,
  input  logic          ram_rvalid,
  output logic          rd_err
);

  state_t      state;
  logic [1:0]  off_q;
  logic [31:0] lo_q;
  logic        err_q;
  logic        expired;
  logic [31:0] merged;
  logic        unused_addr;

  assign unused_addr = ^addr;

  mem_rd_align u_align (
    .lo   (lo_q),
    .hi   (ram_rdata),
    .off  (off_q),
    .data (merged)
  );

`ifdef MEM_RD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  assign expired = (wait_cnt == CW'(TIMEOUT - 1));

  // Counts RAM wait cycles of the current access. Any completion, a flush
  // into DRAIN, or leaving the access states restarts it, so every RD0, RD1
  // and DRAIN entry begins at zero.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == RESP || ram_rvalid ||
        ((state == RD0 || state == RD1) && !mre))
      wait_cnt <= '0;
    else if (!expired)
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic unused_timeout;

  assign expired        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Main FSM. ram_re/ram_addr are registered and stay stable until the RAM
  // completes. A flush (mre low) with no completion moves to DRAIN to finish
  // the outstanding RAM access; with a completion in the same cycle the
  // access is already over, so it goes straight to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_val  <= '0;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      off_q    <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mre) begin
            state    <= RD0;
            ram_re   <= 1'b1;
            ram_addr <= addr[AW+1:2];
            off_q    <= addr[1:0];
            err_q    <= 1'b0;
          end
        end
        RD0: begin
          if (ram_rvalid) begin
            lo_q <= ram_rdata;
            if (!mre) begin
              state  <= IDLE;
              ram_re <= 1'b0;
            end else if (off_q == 2'd0) begin
              mem_val <= ram_rdata;
              state   <= RESP;
              ram_re  <= 1'b0;
            end else begin
              state    <= RD1;
              ram_addr <= ram_addr + 1'b1;
            end
          end else if (!mre) begin
            state <= DRAIN;
          end else if (expired) begin
            mem_val <= ERR_VALUE;
            err_q   <= 1'b1;
            state   <= RESP;
            ram_re  <= 1'b0;
          end
        end
        RD1: begin
          if (ram_rvalid) begin
            ram_re <= 1'b0;
            if (mre) begin
              mem_val <= merged;
              state   <= RESP;
            end else begin
              state <= IDLE;
            end
          end else if (!mre) begin
            state <= DRAIN;
          end else if (expired) begin
            mem_val <= ERR_VALUE;
            err_q   <= 1'b1;
            state   <= RESP;
            ram_re  <= 1'b0;
          end
        end
        RESP: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        DRAIN: begin
          if (ram_rvalid || expired) begin
            state  <= IDLE;
            ram_re <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          ram_re <= 1'b0;
        end
      endcase
    end
  end

  // A stage flushed during RESP no longer wants the data, so the pulse
  // follows mre.
  assign read_finished = (state == RESP) && mre;
  assign rd_err        = read_finished && err_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_rd_responder.sv
// tb_mem_rd_responder
//   Self-checking bench for mem_rd_responder (AW=4 so word wrap is reachable).
//   A RAM model with per-access wait counts feeds the DUT; expected data is
//   assembled byte by byte from the RAM contents, and latencies follow from
//   the chosen wait counts.
module tb_mem_rd_responder;

  localparam int AW = 4;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          mre;
  logic [31:0]   addr;
  logic          read_finished;
  logic [31:0]   mem_val;
  logic          busy;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          ram_rvalid;
  logic          rd_err;

  int checks = 0;
  int errors = 0;

  logic [31:0]   mem [NWORDS];
  int            waits_q[$];
  logic [AW-1:0] acc_q[$];
  bit            hang = 1'b0;
  logic [31:0]   exp_val = 32'h0;

  int ram_wl = 0;
  bit ram_active = 1'b0;

  always #5 clk = ~clk;

  mem_rd_responder #(.AW(AW), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .mre           (mre),
    .addr          (addr),
    .read_finished (read_finished),
    .mem_val       (mem_val),
    .busy          (busy),
    .ram_re        (ram_re),
    .ram_addr      (ram_addr),
    .ram_rdata     (ram_rdata),
    .ram_rvalid    (ram_rvalid),
    .rd_err        (rd_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Reference read: gather four bytes starting at the byte address, taking
  // each from whichever word (mod the RAM size) holds it.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    int          base;
    int          idx;
    int          word;
    r    = '0;
    base = int'(a[AW+1:2]);
    for (int k = 0; k < 4; k++) begin
      idx  = int'(a[1:0]) + k;
      word = (base + idx / 4) % NWORDS;
      r[8*k +: 8] = 8'(mem[word] >> (8 * (idx % 4)));
    end
    return r;
  endfunction

  // RAM model: each access (ram_re first seen) takes the next wait count
  // from waits_q, then returns the addressed word with ram_rvalid.
  initial begin
    ram_rvalid = 1'b0;
    ram_rdata  = '0;
    forever begin
      @(negedge clk);
      ram_rvalid = 1'b0;
      if (ram_re !== 1'b1) begin
        ram_active = 1'b0;
      end else begin
        if (!ram_active) begin
          ram_active = 1'b1;
          ram_wl     = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
          acc_q.push_back(ram_addr);
        end
        if (!hang) begin
          if (ram_wl == 0) begin
            ram_rvalid = 1'b1;
            ram_rdata  = mem[ram_addr];
            ram_active = 1'b0;
          end else begin
            ram_wl--;
          end
        end
      end
    end
  end

  task automatic checkAccesses(input string tag, input logic [31:0] a, input int n);
    logic [AW-1:0] w;
    logic [AW-1:0] want;
    w = a[AW+1:2];
    checkOutput({tag, " acc_count"}, 32'(acc_q.size()), 32'(n));
    for (int e = 0; e < n; e++) begin
      want = w + AW'(e);
      checkOutput({tag, " acc_addr"},
                  (e < acc_q.size()) ? 32'(acc_q[e]) : 32'hFFFF_FFFF, 32'(want));
    end
  endtask

  // One request. flush_at==0: run to completion and check latency/data.
  // flush_at==k: withdraw mre after the k-th cycle of RD0 (k <= w0+1).
  task automatic applyStimulus(input logic [31:0] a, input int w0, input int w1,
                               input int flush_at, input string tag);
    bit unaligned;
    int lat;
    int exp_lat;
    int pulses;
    int idle_n;
    unaligned = (a[1:0] != 2'd0);
    @(negedge clk);
    acc_q.delete();
    waits_q.delete();
    waits_q.push_back(w0);
    waits_q.push_back(w1);
    addr = a;
    mre  = 1'b1;
    if (flush_at == 0) begin
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
        @(negedge clk);
        if (read_finished) begin
          lat = n;
          break;
        end
      end
      exp_lat = unaligned ? (3 + w0 + w1) : (2 + w0);
      exp_val = model_read(a);
      checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, " mem_val"}, mem_val, exp_val);
      checkOutput({tag, " rd_err"}, 32'(rd_err), 32'd0);
      checkAccesses(tag, a, unaligned ? 2 : 1);
      @(posedge clk);
      #1 mre = 1'b0;
      @(negedge clk);
      checkOutput({tag, " pulse_end"}, 32'(read_finished), 32'd0);
      checkOutput({tag, " idle_busy"}, 32'(busy), 32'd0);
    end else begin
      pulses = 0;
      idle_n = 0;
      for (int n = 1; n <= flush_at; n++) begin
        @(negedge clk);
        pulses += int'(read_finished);
      end
      mre = 1'b0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        pulses += int'(read_finished);
        if (!busy) begin
          idle_n = n;
          break;
        end
        checkOutput({tag, " drain_re"}, 32'(ram_re), 32'd1);
        checkOutput({tag, " drain_addr"}, 32'(ram_addr), 32'(a[AW+1:2]));
      end
      checkOutput({tag, " flush_pulses"}, 32'(pulses), 32'd0);
      checkOutput({tag, " flush_idle"}, 32'(idle_n), 32'(2 + w0 - flush_at));
      checkOutput({tag, " flush_mem_val"}, mem_val, exp_val);
      checkAccesses(tag, a, 1);
    end
  endtask

  initial begin
    int p1;
    int p2;
    int lat;
    logic re3;
    logic busy3;
    logic [31:0] a;
    int w0;
    int w1;
    int k;

    rst  = 1'b1;
    mre  = 1'b0;
    addr = '0;
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    checkOutput("rst read_finished", 32'(read_finished), 32'd0);
    checkOutput("rst mem_val", mem_val, 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst ram_re", 32'(ram_re), 32'd0);
    checkOutput("rst ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst rd_err", 32'(rd_err), 32'd0);
    rst = 1'b0;

    // Directed cases.
    mem[4] = 32'hDEAD_BEEF;
    applyStimulus(32'h0000_0010, 0, 0, 0, "aligned");
    checkOutput("aligned value", mem_val, 32'hDEAD_BEEF);
    mem[4] = 32'h4433_2211;
    mem[5] = 32'h8877_6655;
    applyStimulus(32'h0000_0013, 0, 0, 0, "unaligned");
    checkOutput("unaligned value", mem_val, 32'h7766_5544);
    mem[15] = 32'h0000_00AA;
    mem[0]  = 32'h0000_00BB;
    applyStimulus(32'h0000_003E, 0, 0, 0, "wrap");
    checkOutput("wrap value", mem_val, 32'h00BB_0000);
    applyStimulus(32'h0000_0024, 3, 0, 1, "flush_stall");
    applyStimulus(32'h0000_0029, 0, 0, 1, "flush_same");

    // Back-to-back aligned reads with mre held.
    mem[8] = 32'h1234_5678;
    @(negedge clk);
    waits_q.delete();
    waits_q.push_back(0);
    waits_q.push_back(0);
    addr = 32'h0000_0020;
    mre  = 1'b1;
    p1 = 0;
    p2 = 0;
    re3 = 1'b1;
    busy3 = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 3) begin
        re3   = ram_re;
        busy3 = busy;
      end
      if (read_finished) begin
        if (p1 == 0) p1 = n;
        else if (p2 == 0) p2 = n;
      end
    end
    @(posedge clk);
    #1 mre = 1'b0;
    exp_val = 32'h1234_5678;
    checkOutput("b2b first", 32'(p1), 32'd2);
    checkOutput("b2b second", 32'(p2), 32'd5);
    checkOutput("b2b gap ram_re", 32'(re3), 32'd0);
    checkOutput("b2b gap busy", 32'(busy3), 32'd0);
    checkOutput("b2b mem_val", mem_val, exp_val);

    // Reset while waiting in RD1.
    @(negedge clk);
    waits_q.delete();
    waits_q.push_back(0);
    waits_q.push_back(8);
    addr = 32'h0000_0009;
    mre  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rd1 ram_re", 32'(ram_re), 32'd1);
    checkOutput("rd1 ram_addr", 32'(ram_addr), 32'd3);
    rst = 1'b1;
    mre = 1'b0;
    @(negedge clk);
    checkOutput("midrst read_finished", 32'(read_finished), 32'd0);
    checkOutput("midrst mem_val", mem_val, 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst ram_re", 32'(ram_re), 32'd0);
    checkOutput("midrst ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("midrst rd_err", 32'(rd_err), 32'd0);
    rst = 1'b0;
    exp_val = 32'h0;

`ifdef MEM_RD_TIMEOUT_EN
    // RAM never answers: error response after 16 RD0 cycles plus RESP.
    @(negedge clk);
    waits_q.delete();
    hang = 1'b1;
    addr = 32'h0000_0014;
    mre  = 1'b1;
    lat  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (read_finished) begin
        lat = n;
        break;
      end
    end
    checkOutput("timeout latency", 32'(lat), 32'd17);
    checkOutput("timeout rd_err", 32'(rd_err), 32'd1);
    checkOutput("timeout mem_val", mem_val, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 mre = 1'b0;
    @(negedge clk);
    checkOutput("timeout ram_re", 32'(ram_re), 32'd0);
    hang = 1'b0;
    exp_val = 32'hFFFF_FFFF;
`endif

    // Randomized reads and flushes.
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      w0 = $urandom_range(0, 3);
      w1 = $urandom_range(0, 3);
      k  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, w0 + 1) : 0;
      if (i % 8 == 0) mem[$urandom_range(0, NWORDS - 1)] = $urandom;
      applyStimulus(a, w0, w1, k, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
